// File: rtl/comp_nbit_seq.sv
// Multi-cycle MSB-first magnitude comparator with signed mode, optional early exit and start/busy/done handshake.
// Latency: first differing slice index (EARLY_EXIT=1) or WIDTH/DIGIT cycles; start ignored while busy.
module comp_nbit_seq #(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 2,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                signed_mode,
  input  logic [WIDTH-1:0]                    a,
  input  logic [WIDTH-1:0]                    b,
  output logic                                busy,
  output logic                                done,
  output logic                                alb,
  output logic                                aeb,
  output logic                                agb,
  output logic [$clog2(WIDTH/DIGIT+1)-1:0]    slices
);

  localparam int NSL = WIDTH / DIGIT;
  localparam int CW  = $clog2(NSL + 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST_CNT = CW'(NSL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q, sb_q;
  logic [CW-1:0]    cnt_q, slices_q;
  logic             busy_q, done_q, alb_q, aeb_q, agb_q;
  logic             dec_q, lt_q, gt_q;

  logic [DIGIT-1:0] top_a, top_b;
  logic             slice_lt, slice_gt, slice_ne, last_slice;
  logic             fin_lt, fin_gt;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] cap_a_d, cap_b_d;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    top_a      = sa_q[WIDTH-1 -: DIGIT];
    top_b      = sb_q[WIDTH-1 -: DIGIT];
    slice_lt   = top_a < top_b;
    slice_gt   = top_a > top_b;
    slice_ne   = top_a != top_b;
    cnt_d      = cnt_q + 1'b1;
    last_slice = cnt_q == LAST_CNT;
    fin_lt     = dec_q ? lt_q : slice_lt;
    fin_gt     = dec_q ? gt_q : slice_gt;
    cap_a_d    = a ^ (signed_mode ? MSB_MASK : '0);
    cap_b_d    = b ^ (signed_mode ? MSB_MASK : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      cnt_q    <= '0;
      slices_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      alb_q    <= 1'b0;
      aeb_q    <= 1'b0;
      agb_q    <= 1'b0;
      dec_q    <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            sa_q    <= cap_a_d;
            sb_q    <= cap_b_d;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          cnt_q <= cnt_d;
          sa_q  <= sa_q << DIGIT;
          sb_q  <= sb_q << DIGIT;
          if (slice_ne && !dec_q) begin
            dec_q <= 1'b1;
            lt_q  <= slice_lt;
            gt_q  <= slice_gt;
          end
          // Result flags and slice count only move here, so they hold across a new start.
          if ((EARLY_EXIT && slice_ne) || last_slice) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            alb_q    <= fin_lt;
            agb_q    <= fin_gt;
            aeb_q    <= !(dec_q || slice_ne);
            slices_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign alb    = alb_q;
  assign aeb    = aeb_q;
  assign agb    = agb_q;
  assign slices = slices_q;

endmodule

// File: tb/tb_comp_nbit_seq.sv
// Scoreboard bench for comp_nbit_seq: three builds (early exit, constant latency, single-slice) share operands.
module tb_comp_nbit_seq;

  typedef struct {
    logic lt;
    logic eq;
    logic gt;
    int   sl;
    int   s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic        sm = 1'b0;
  logic        st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;

  logic        busy0, done0, alb0, aeb0, agb0;
  logic        busy1, done1, alb1, aeb1, agb1;
  logic        busy2, done2, alb2, aeb2, agb2;
  logic [3:0]  slc0, slc1;
  logic [0:0]  slc2;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  comp_nbit_seq #(.WIDTH(16), .DIGIT(2), .EARLY_EXIT(1'b1)) dut0 (
    .clk(clk), .rst(rst), .start(st0), .signed_mode(sm), .a(a), .b(b),
    .busy(busy0), .done(done0), .alb(alb0), .aeb(aeb0), .agb(agb0), .slices(slc0));

  comp_nbit_seq #(.WIDTH(16), .DIGIT(2), .EARLY_EXIT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .signed_mode(sm), .a(a), .b(b),
    .busy(busy1), .done(done1), .alb(alb1), .aeb(aeb1), .agb(agb1), .slices(slc1));

  comp_nbit_seq #(.WIDTH(16), .DIGIT(16), .EARLY_EXIT(1'b1)) dut2 (
    .clk(clk), .rst(rst), .start(st2), .signed_mode(sm), .a(a), .b(b),
    .busy(busy2), .done(done2), .alb(alb2), .aeb(aeb2), .agb(agb2), .slices(slc2));

  function automatic int dig_of(input int d);
    return (d == 2) ? 16 : 2;
  endfunction

  function automatic bit ee_of(input int d);
    return d != 1;
  endfunction

  function automatic logic get_done(input int d);
    case (d)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic [2:0] get_flags(input int d);
    case (d)
      0: return {alb0, aeb0, agb0};
      1: return {alb1, aeb1, agb1};
      default: return {alb2, aeb2, agb2};
    endcase
  endfunction

  function automatic int get_sl(input int d);
    case (d)
      0: return int'(slc0);
      1: return int'(slc1);
      default: return int'(slc2);
    endcase
  endfunction

  // Reference: order from integer compare; first differing slice from the top set bit of a^b.
  function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib, input logic ism,
                                 input int dig, input bit ee, input int s);
    exp_t e;
    int   n;
    int   h;
    n = 16 / dig;
    h = -1;
    for (int i = 0; i < 16; i++) if (ia[i] !== ib[i]) h = i;
    if (ism) begin
      e.lt = $signed(ia) < $signed(ib);
      e.gt = $signed(ia) > $signed(ib);
    end else begin
      e.lt = ia < ib;
      e.gt = ia > ib;
    end
    e.eq = ia == ib;
    e.sl = (h < 0 || !ee) ? n : (15 - h) / dig + 1;
    e.s  = s;
    return e;
  endfunction

  function automatic exp_t pop_exp(input int d);
    case (d)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic set_start(input int d, input logic v);
    case (d)
      0: st0 = v;
      1: st1 = v;
      default: st2 = v;
    endcase
  endtask

  // Called at a falling edge; start is sampled on the next rising edge.
  task automatic issue(input int d, input logic [15:0] ia, input logic [15:0] ib, input logic ism);
    exp_t e;
    a  = ia;
    b  = ib;
    sm = ism;
    set_start(d, 1'b1);
    e = model(ia, ib, ism, dig_of(d), ee_of(d), cyc + 1);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    @(negedge clk);
    set_start(d, 1'b0);
    a  = 16'($urandom);
    b  = 16'($urandom);
    sm = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int d, output int dc, output bit ok);
    ok = 1'b0;
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (get_done(d) === 1'b1) begin
        ok = 1'b1;
        dc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({get_busy(d), get_done(d), get_flags(d)} !== 5'b0 || get_sl(d) !== 0) begin
        errors++;
        $display("FAIL reset_state dut%0d: busy=%b done=%b flags=%b slices=%0d, required all 0",
                 d, get_busy(d), get_done(d), get_flags(d), get_sl(d));
      end
    end
  endtask

  task automatic test_vectors(input int d);
    logic [15:0] va [16];
    logic [15:0] vb [16];
    logic        vs [16];
    exp_t        e;
    int          dc;
    bit          ok;
    va[0] = 16'h8000; vb[0] = 16'h7FFF; vs[0] = 1'b0;
    va[1] = 16'h8000; vb[1] = 16'h7FFF; vs[1] = 1'b1;
    va[2] = 16'h1234; vb[2] = 16'h1234; vs[2] = 1'b0;
    va[3] = 16'h8000; vb[3] = 16'h0000; vs[3] = 1'b0;
    va[4] = 16'h0001; vb[4] = 16'h0002; vs[4] = 1'b0;
    va[5] = 16'hFFFF; vb[5] = 16'h0001; vs[5] = 1'b1;
    va[6] = 16'h0003; vb[6] = 16'h0004; vs[6] = 1'b0;
    va[7] = 16'h7FFF; vb[7] = 16'h8000; vs[7] = 1'b1;
    for (int i = 8; i < 16; i++) begin
      va[i] = 16'($urandom);
      vb[i] = ($urandom_range(0, 1) == 1) ? (va[i] ^ (16'h0001 << $urandom_range(0, 15))) : 16'($urandom);
      vs[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 16; i++) begin
      issue(d, va[i], vb[i], vs[i]);
      wait_done(d, dc, ok);
      e = pop_exp(d);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL vec_timeout dut%0d #%0d: no done within 40 cycles, required done", d, i);
        continue;
      end
      checks++;
      if (get_flags(d) !== {e.lt, e.eq, e.gt}) begin
        errors++;
        $display("FAIL vec_flags dut%0d #%0d a=%h b=%h s=%b: got %b, required %b",
                 d, i, va[i], vb[i], vs[i], get_flags(d), {e.lt, e.eq, e.gt});
      end
      checks++;
      if (get_sl(d) !== e.sl) begin
        errors++;
        $display("FAIL vec_slices dut%0d #%0d a=%h b=%h: got %0d, required %0d",
                 d, i, va[i], vb[i], get_sl(d), e.sl);
      end
      checks++;
      if (dc - e.s !== e.sl) begin
        errors++;
        $display("FAIL vec_latency dut%0d #%0d a=%h b=%h: got %0d, required %0d",
                 d, i, va[i], vb[i], dc - e.s, e.sl);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_busy_window();
    exp_t e;
    int   bc;
    int   dc;
    bit   ok;
    issue(0, 16'h1234, 16'h1234, 1'b0);
    e  = pop_exp(0);
    bc = 0;
    ok = 1'b0;
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (done0 === 1'b1) begin
        ok = 1'b1;
        dc = cyc;
        break;
      end
      if (busy0 === 1'b1) bc++;
      @(negedge clk);
    end
    checks++;
    if (!ok || bc != 8 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL busy_window: done=%0b busy_cycles=%0d busy_at_done=%b, required done busy_cycles=8 busy_at_done=0",
               ok, bc, busy0);
    end
    checks++;
    if ({alb0, aeb0, agb0} !== 3'b010 || slc0 !== 4'd8 || dc - e.s != 8) begin
      errors++;
      $display("FAIL equal_result: flags=%b slices=%0d latency=%0d, required flags=010 slices=8 latency=8",
               {alb0, aeb0, agb0}, slc0, dc - e.s);
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    exp_t e;
    int   dc;
    int   extra;
    bit   ok;
    issue(0, 16'h0100, 16'h0200, 1'b0);
    a   = 16'hFFFF;
    b   = 16'h0000;
    sm  = 1'b1;
    st0 = 1'b1;
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b, required 1", busy0);
    end
    @(negedge clk);
    @(negedge clk);
    st0 = 1'b0;
    wait_done(0, dc, ok);
    e = pop_exp(0);
    checks++;
    if (!ok || {alb0, aeb0, agb0} !== 3'b100 || slc0 !== 4'd4 || dc - e.s != 4) begin
      errors++;
      $display("FAIL busy_ignore: done=%0b flags=%b slices=%0d latency=%0d, required done flags=100 slices=4 latency=4",
               ok, {alb0, aeb0, agb0}, slc0, dc - e.s);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || {alb0, aeb0, agb0} !== 3'b100 || slc0 !== 4'd4) begin
      errors++;
      $display("FAIL busy_ignore_hold: extra_done=%0d flags=%b slices=%0d, required 0 100 4",
               extra, {alb0, aeb0, agb0}, slc0);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   extra;
    issue(0, 16'hFFFF, 16'hFFFF, 1'b0);
    e = pop_exp(0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b1 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL run_before_abort: busy=%b done=%b, required busy=1 done=0", busy0, done0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy0, done0, alb0, aeb0, agb0} !== 5'b0 || slc0 !== 4'd0) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b flags=%b slices=%0d, required all 0",
               busy0, done0, {alb0, aeb0, agb0}, slc0);
    end
    checks++;
    if ({alb1, aeb1, agb1} !== 3'b0 || slc1 !== 4'd0) begin
      errors++;
      $display("FAIL abort_other_dut: flags=%b slices=%0d, required 000 0", {alb1, aeb1, agb1}, slc1);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done0 === 1'b1 || busy0 === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d busy/done cycles, required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   dc;
    int   hold_bad;
    bit   ok;
    issue(1, 16'hC000, 16'h4000, 1'b0);
    wait_done(1, dc, ok);
    e = pop_exp(1);
    checks++;
    if (!ok || {alb1, aeb1, agb1} !== 3'b001 || slc1 !== 4'd8 || dc - e.s != 8) begin
      errors++;
      $display("FAIL b2b_first: done=%0b flags=%b slices=%0d latency=%0d, required done flags=001 slices=8 latency=8",
               ok, {alb1, aeb1, agb1}, slc1, dc - e.s);
    end
    issue(1, 16'h0003, 16'h0004, 1'b0);
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_bubble: busy=%b done=%b, required busy=1 done=0", busy1, done1);
    end
    hold_bad = 0;
    ok = 1'b0;
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (done1 === 1'b1) begin
        ok = 1'b1;
        dc = cyc;
        break;
      end
      if ({alb1, aeb1, agb1} !== 3'b001 || slc1 !== 4'd8) hold_bad++;
      @(negedge clk);
    end
    e = pop_exp(1);
    checks++;
    if (hold_bad != 0) begin
      errors++;
      $display("FAIL b2b_hold: got %0d cycles with changed result, required 0", hold_bad);
    end
    checks++;
    if (!ok || {alb1, aeb1, agb1} !== 3'b100 || slc1 !== 4'd8 || dc - e.s != 8) begin
      errors++;
      $display("FAIL b2b_second: done=%0b flags=%b slices=%0d latency=%0d, required done flags=100 slices=8 latency=8",
               ok, {alb1, aeb1, agb1}, slc1, dc - e.s);
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_pulse: done=%b busy=%b, required 0 0", done1, busy1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_vectors(0);
    test_vectors(1);
    test_vectors(2);
    test_busy_window();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comp_nbit_seq.md
Name: comp_nbit_seq

Overview:
Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands, processed MSB-first DIGIT bits per clock. It produces the same one-hot less/equal/greater flags as the 2-bit combinational comparator. It adds:
- signed (two's-complement) mode;
- early termination on the first differing slice;
- a start/busy/done handshake.

It sits beside the datapath wherever wide compares must not sit in one combinational cone.

Parameters:
WIDTH, 16, operand width in bits; must be an integer multiple of DIGIT, minimum 2.
DIGIT, 2, bits compared per clock (slice width); 1 <= DIGIT <= WIDTH.
EARLY_EXIT, 1, 1 = finish on first differing slice; 0 = always examine all WIDTH/DIGIT slices (constant latency).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
signed_mode  input  1  1 = two's-complement compare; sampled with start.
a  input  WIDTH  operand A; sampled with start.
b  input  WIDTH  operand B; sampled with start.
busy  output  1  high while in RUN.
done  output  1  single-cycle pulse; result flags valid from this cycle on.
alb  output  1  registered: A < B.
aeb  output  1  registered: A == B.
agb  output  1  registered: A > B.
slices  output  clog2(WIDTH/DIGIT+1)  registered count of slices examined for the last result.

Behaviour:
Clock and reset:
- Single clock domain, clk.
- rst is synchronous, active-high; it overrides everything.

Reset values:
- State = IDLE.
- busy=0, done=0, alb=0, aeb=0, agb=0, slices=0.
- Internal shift registers cleared.

States: IDLE, RUN, DONE.

IDLE:
- On a clk edge with start=1, capture a and b into shift registers sa and sb.
- If signed_mode=1, invert bit WIDTH-1 of both captured operands. This makes the unsigned slice compare give the signed order.
- Clear the slice counter and go to RUN.
- start=0: stay in IDLE.

RUN (busy=1):
- Each cycle compare the top slices sa[WIDTH-1 -: DIGIT] and sb[WIDTH-1 -: DIGIT] as unsigned values, and increment the slice counter.
- First differing slice (EARLY_EXIT=1):
  - latch agb = (slice_a > slice_b), alb = (slice_a < slice_b), aeb=0;
  - load slices with the count including this slice;
  - go to DONE.
- EARLY_EXIT=0:
  - the first differing slice is recorded in a sticky decided flag and sticky lt/gt flags;
  - later slices do not alter them.
- Otherwise shift sa and sb left by DIGIT.
- After the last slice (WIDTH/DIGIT examined):
  - latch the result; aeb=1 if no slice differed;
  - slices = WIDTH/DIGIT;
  - go to DONE.

DONE:
- done=1 for exactly this cycle.
- Next state is IDLE, or RUN if start=1 in this cycle. Back-to-back requests are accepted with no idle bubble.

Latency:
- done rises k cycles after the start-sampling edge.
- k = index (1-based) of the first differing slice if EARLY_EXIT=1, else WIDTH/DIGIT.
- Equal operands always take WIDTH/DIGIT cycles.

Result outputs:
- alb/aeb/agb and slices hold their value until the next DONE. They do not clear on a new start.
- After the first completed compare the flags are always exactly one-hot.

Boundary conditions:
- start while busy=1: ignored; a, b and signed_mode are not re-sampled.
- rst during RUN or DONE: the operation is aborted; no done pulse; all outputs return to reset values.
- DIGIT=WIDTH: a single RUN cycle; done at k=1.
- Operands may change freely after the sampling edge.

Test Plan:
1. WIDTH=16, DIGIT=2, EARLY_EXIT=1; unsigned; a=0x8000, b=0x7FFF; start pulse -> done 1 cycle after sampling edge; agb=1, alb=0, aeb=0; slices=1.
2. Same operands, signed_mode=1 -> alb=1, agb=0, aeb=0; slices=1.
3. a=b=0x1234, unsigned -> aeb=1; slices=8; done exactly 8 cycles after start edge; busy high for exactly those 8 cycles.
4. EARLY_EXIT=0 build; a=0x8000, b=0x0000 -> agb=1; slices=8; done after 8 cycles. a=0x0001, b=0x0002 -> alb=1 after 8 cycles.
5. Start compare a=b=0xFFFF; assert rst for one cycle at RUN cycle 3 -> no done pulse; busy=0, all flags 0, slices=0 next cycle. Also assert start with new operands while busy -> ignored, original result unchanged.
6. Back-to-back: a second start during the DONE cycle (a=0x0003, b=0x0004, unsigned) -> RUN entered with no IDLE cycle. First result holds until second done. Second result alb=1, slices=8.
